instruction_encoder: RTL
========================

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the instruction-memory address width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 2, meaning the encoded-word buffer depth (power of two, at least 2).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: i_clk  in  1  clock, rising edge; i_reset  in  1  asynchronous active-high reset.
REQ-004 The block SHALL have these ports: i_start  in  1  begin program load (pulse, honoured in IDLE only).
REQ-005 i_base_addr  in  ADDR_W  first write address, sampled with i_start.
REQ-006 i_length  in  ADDR_W+1  number of instructions to load, sampled with i_start.
REQ-007 i_valid  in  1  instruction fields valid; o_ready  out  1  block accepts fields this cycle.
REQ-008 i_opcode  in  8; i_rs1  in  4; i_rs2  in  4; i_rd  in  4; i_i  in  16: instruction fields.
REQ-009 o_mem_we  out  1; o_mem_addr  out  ADDR_W; o_mem_wdata  out  32; i_mem_ready  in  1: memory write port.
REQ-010 o_busy  out  1  not IDLE; o_done  out  1  one-cycle completion pulse; o_error  out  1  sticky unknown-opcode flag.

Function
REQ-011 Opcodes SHALL be NOP=0, LDA=1, STA=2, ADD=3, SUB=4; word[31:24] SHALL always equal i_opcode.
REQ-012 LDA SHALL encode rd at [23:20] and imm at [15:0]; STA SHALL encode rs1 at [23:20] and imm at [15:0]; ADD/SUB SHALL encode rd at [23:20], rs1 at [7:4] and rs2 at [3:0].
REQ-013 All bits not named for an opcode SHALL be zero; unused fields SHALL be ignored; NOP SHALL encode as 0x00000000.
REQ-014 An unknown opcode SHALL encode as {opcode, 24'h0}, SHALL still be written, and SHALL set o_error until the next accepted i_start.
REQ-015 The FSM SHALL have the states IDLE, LOAD, FLUSH and DONE.
REQ-016 IDLE with i_start: load the address counter with i_base_addr, clear the counters and o_error, and go to LOAD; if i_length==0, go to DONE.
REQ-017 o_ready SHALL be 1 only in LOAD, with the FIFO not full and accepted < length; a handshake is i_valid & o_ready.
REQ-018 A handshake SHALL push the encoded word; LOAD SHALL go to FLUSH on the cycle the accepted count reaches length.
REQ-019 o_mem_we SHALL equal FIFO-not-empty; o_mem_wdata SHALL be the FIFO head; o_mem_addr SHALL be the address counter.
REQ-020 A write completes on o_mem_we & i_mem_ready: pop, and address+1 modulo 2^ADDR_W (wrap from max to 0).
REQ-021 While o_mem_we=1 and i_mem_ready=0, o_mem_wdata and o_mem_addr SHALL hold stable.
REQ-022 Latency: a word accepted at edge N SHALL appear with o_mem_we=1 after edge N when the FIFO was empty.
REQ-023 A push and a pop in the same cycle SHALL leave the occupancy unchanged; full or empty SHALL never be over- or under-run.
REQ-024 FLUSH SHALL go to DONE when the written count equals length; DONE SHALL assert o_done for exactly one cycle, then return to IDLE.
REQ-025 i_start outside IDLE SHALL be ignored.

Reset
REQ-026 i_reset SHALL asynchronously force IDLE, empty the FIFO, zero all counters and the address, and drive o_ready, o_mem_we, o_busy, o_done and o_error to 0 and o_mem_addr and o_mem_wdata to 0.
REQ-027 Reset in mid-operation SHALL discard buffered words with no further writes, and operation SHALL resume only on a new i_start.

Structure
REQ-028 The opcode constants and the field bit positions ([31:24], [23:20], [15:0], [7:4], [3:0]) SHALL live in a shared package used by both encoder and decoder.
REQ-029 The buffer SHALL be a sub-module, instruction_fifo (parameter DEPTH, width 32, push/pop/full/empty).

Verification
REQ-030 Scenario: base=0x10, len=4; LDA rd3 imm0x1234, ADD rd2 rs1=5 rs2=7, STA rs1=4 imm0x00FF, SUB rd1 rs1=2 rs2=3 -> writes 0x01301234@0x10, 0x03200057@0x11, 0x024000FF@0x12, 0x04100023@0x13, then o_done pulses once.
REQ-031 Scenario: LDA rd3 imm0x1234 with rs1=0xF, rs2=0xF -> 0x01301234 (stray fields ignored).
REQ-032 Scenario: base=0xFE, len=3 with NOPs -> addresses 0xFE, 0xFF, 0x00 and data 0x00000000.
REQ-033 Scenario: i_mem_ready=0 for 5 cycles while i_valid=1 -> o_ready drops after 2 accepts, o_mem_wdata/o_mem_addr hold, no words lost or duplicated.
REQ-034 Scenario: opcode 0x7A, rd=1 -> 0x7A000000 written, o_error=1 through DONE, cleared by next i_start; len=0 -> o_done one cycle after start, no writes.
REQ-035 Scenario: i_reset mid-FLUSH with 2 words buffered -> o_mem_we=0 immediately, o_busy=0, no further writes until the next i_start.

Source files
------------

// File: rtl/instruction_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instruction_encoder_pkg
// Shared definitions for the instruction encoder (and its companion decoder):
//   - opcode constants
//   - instruction-word field bit positions
//   - controller state encoding
//   - helper functions to classify and encode an instruction
// -----------------------------------------------------------------------------
package instruction_encoder_pkg;

    // Opcode constants
    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LDA = 8'h01;
    localparam logic [7:0] OP_STA = 8'h02;
    localparam logic [7:0] OP_ADD = 8'h03;
    localparam logic [7:0] OP_SUB = 8'h04;

    // Instruction-word field positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 24;
    localparam int DST_MSB = 23;   // rd for LDA/ADD/SUB, rs1 for STA
    localparam int DST_LSB = 20;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_e;

    // True when the opcode is one the encoder knows how to lay out.
    function automatic logic is_known_opcode(input logic [7:0] opcode);
        logic known;
        case (opcode)
            OP_NOP, OP_LDA, OP_STA, OP_ADD, OP_SUB: known = 1'b1;
            default:                                known = 1'b0;
        endcase
        return known;
    endfunction

    // Build the 32-bit instruction word. Fields not used by the opcode are
    // dropped; unknown opcodes keep only the opcode byte.
    function automatic logic [31:0] encode_instr(
        input logic [7:0]  opcode,
        input logic [3:0]  rs1,
        input logic [3:0]  rs2,
        input logic [3:0]  rd,
        input logic [15:0] imm
    );
        logic [31:0] word;
        word                  = 32'h0000_0000;
        word[OPC_MSB:OPC_LSB] = opcode;
        case (opcode)
            OP_LDA: begin
                word[DST_MSB:DST_LSB] = rd;
                word[IMM_MSB:IMM_LSB] = imm;
            end
            OP_STA: begin
                word[DST_MSB:DST_LSB] = rs1;
                word[IMM_MSB:IMM_LSB] = imm;
            end
            OP_ADD, OP_SUB: begin
                word[DST_MSB:DST_LSB] = rd;
                word[RS1_MSB:RS1_LSB] = rs1;
                word[RS2_MSB:RS2_LSB] = rs2;
            end
            default: begin
                // NOP (opcode 0) and unknown opcodes carry the opcode byte only
                word[OPC_MSB:OPC_LSB] = opcode;
            end
        endcase
        return word;
    endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// -----------------------------------------------------------------------------
// instruction_encoder_if
// Groups the encoder's control, instruction-stream and memory-write signals.
//   master : the environment (drives start/fields/mem_ready, observes status)
//   slave  : the encoder
// Signals:
//   i_start, i_base_addr, i_length      program-load request
//   i_valid, o_ready, i_opcode, i_rs1,
//   i_rs2, i_rd, i_i                    instruction-field handshake
//   o_mem_we, o_mem_addr, o_mem_wdata,
//   i_mem_ready                         memory write port
//   o_busy, o_done, o_error             status
// -----------------------------------------------------------------------------
interface instruction_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              i_start;
    logic [ADDR_W-1:0] i_base_addr;
    logic [ADDR_W:0]   i_length;
    logic              i_valid;
    logic              o_ready;
    logic [7:0]        i_opcode;
    logic [3:0]        i_rs1;
    logic [3:0]        i_rs2;
    logic [3:0]        i_rd;
    logic [15:0]       i_i;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic              i_mem_ready;
    logic              o_busy;
    logic              o_done;
    logic              o_error;

    modport master (
        output i_start, i_base_addr, i_length,
        output i_valid, i_opcode, i_rs1, i_rs2, i_rd, i_i,
        output i_mem_ready,
        input  o_ready, o_mem_we, o_mem_addr, o_mem_wdata,
        input  o_busy, o_done, o_error
    );

    modport slave (
        input  i_start, i_base_addr, i_length,
        input  i_valid, i_opcode, i_rs1, i_rs2, i_rd, i_i,
        input  i_mem_ready,
        output o_ready, o_mem_we, o_mem_addr, o_mem_wdata,
        output o_busy, o_done, o_error
    );

endinterface

// File: rtl/instruction_encoder_fifo.sv
// -----------------------------------------------------------------------------
// instruction_fifo
// Small 32-bit word buffer between the encoder and the memory write port.
// Flags and the head word are registered so the write port is driven
// straight from flops.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (empties the buffer)
//   push, din  write a word (ignored when full)
//   pop        drop the head word (ignored when empty)
//   full       no free slot
//   empty      no buffered word
//   dout       head word (zero while empty)
//   count      current occupancy
// -----------------------------------------------------------------------------
module instruction_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [31:0]              din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [31:0]              dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);

    logic [31:0]      mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_r;
    logic             empty_r;
    logic [31:0]      head_r;

    logic             do_push_s;
    logic             do_pop_s;
    logic [PTR_W-1:0] rd_ptr_next_s;
    logic [CNT_W-1:0] count_next_s;
    logic [31:0]      head_next_s;

    assign do_push_s = push & ~full_r;
    assign do_pop_s  = pop & ~empty_r;

    // Next read pointer, occupancy and head word.
    always_comb begin
        rd_ptr_next_s = rd_ptr_r;
        count_next_s  = count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        head_next_s   = 32'h0000_0000;
        if (do_pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        // The incoming word becomes the head only when it lands in the slot
        // the read pointer is about to point at (buffer will hold exactly one).
        if (count_next_s == {CNT_W{1'b0}}) begin
            head_next_s = 32'h0000_0000;
        end else if (do_push_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = din;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Storage, pointers, occupancy and registered flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            head_r   <= 32'h0000_0000;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_next_s;
            full_r   <= (count_next_s == CNT_W'(DEPTH));
            empty_r  <= (count_next_s == {CNT_W{1'b0}});
            head_r   <= head_next_s;
        end
    end

    assign full  = full_r;
    assign empty = empty_r;
    assign dout  = head_r;
    assign count = count_r;

endmodule

// File: rtl/instruction_encoder.sv
// -----------------------------------------------------------------------------
// instruction_encoder
// Accepts a stream of instruction fields, encodes each into a 32-bit word and
// writes the words to consecutive instruction-memory addresses starting at a
// base address. A small buffer decouples field acceptance from memory
// back-pressure.
// Ports:
//   i_clk    clock, rising edge
//   i_reset  asynchronous active-high reset
//   bus      instruction_encoder_if.slave (start/length, field handshake,
//            memory write port, busy/done/error status)
// -----------------------------------------------------------------------------
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    instruction_encoder_if.slave  bus
);
    localparam int LEN_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1'b1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1'b1);

    enc_state_e        state_r;
    enc_state_e        state_next_s;

    logic [ADDR_W-1:0] addr_r;
    logic [LEN_W-1:0]  length_r;
    logic [LEN_W-1:0]  accepted_r;
    logic [LEN_W-1:0]  written_r;
    logic              error_r;
    logic              ready_r;
    logic              busy_r;
    logic              done_r;

    logic              start_accept_s;
    logic              push_s;
    logic              pop_s;
    logic              known_s;
    logic [31:0]       word_s;
    logic [LEN_W-1:0]  accepted_next_s;
    logic [LEN_W-1:0]  length_next_s;
    logic [CNT_W-1:0]  count_next_s;
    logic              ready_next_s;

    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [31:0]       fifo_dout_s;
    logic [CNT_W-1:0]  fifo_count_s;

    assign start_accept_s = (state_r == ST_IDLE) && bus.i_start;
    assign push_s         = bus.i_valid & ready_r & ~fifo_full_s;
    assign pop_s          = ~fifo_empty_s & bus.i_mem_ready;
    assign word_s         = encode_instr(bus.i_opcode, bus.i_rs1, bus.i_rs2, bus.i_rd, bus.i_i);
    assign known_s        = is_known_opcode(bus.i_opcode);
    assign count_next_s   = fifo_count_s + CNT_W'(push_s) - CNT_W'(pop_s);

    instruction_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_reset),
        .push  (push_s),
        .din   (word_s),
        .pop   (pop_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .dout  (fifo_dout_s),
        .count (fifo_count_s)
    );

    // Controller next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_start) begin
                    if (bus.i_length == {LEN_W{1'b0}}) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_LOAD;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (push_s && ((accepted_r + LEN_ONE) == length_r)) begin
                    state_next_s = ST_FLUSH;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_FLUSH: begin
                if (written_r == length_r) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_FLUSH;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // o_ready is registered, so it is computed from next-cycle values of the
    // state, buffer occupancy and accepted count.
    always_comb begin
        accepted_next_s = accepted_r;
        length_next_s   = length_r;
        ready_next_s    = 1'b0;
        if (start_accept_s) begin
            accepted_next_s = {LEN_W{1'b0}};
            length_next_s   = bus.i_length;
        end else if (push_s) begin
            accepted_next_s = accepted_r + LEN_ONE;
        end else begin
            accepted_next_s = accepted_r;
        end
        if ((state_next_s == ST_LOAD) && (count_next_s < DEPTH_C) &&
            (accepted_next_s < length_next_s)) begin
            ready_next_s = 1'b1;
        end else begin
            ready_next_s = 1'b0;
        end
    end

    // Controller state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Address and progress counters.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            addr_r     <= {ADDR_W{1'b0}};
            length_r   <= {LEN_W{1'b0}};
            accepted_r <= {LEN_W{1'b0}};
            written_r  <= {LEN_W{1'b0}};
        end else begin
            if (start_accept_s) begin
                addr_r     <= bus.i_base_addr;
                length_r   <= bus.i_length;
                accepted_r <= {LEN_W{1'b0}};
                written_r  <= {LEN_W{1'b0}};
            end else begin
                accepted_r <= accepted_next_s;
                if (pop_s) begin
                    // Address wraps naturally at 2^ADDR_W
                    addr_r    <= addr_r + ADDR_ONE;
                    written_r <= written_r + LEN_ONE;
                end
            end
        end
    end

    // Registered status outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            error_r <= 1'b0;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            if (start_accept_s) begin
                error_r <= 1'b0;
            end else if (push_s && !known_s) begin
                error_r <= 1'b1;
            end
            ready_r <= ready_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    assign bus.o_ready     = ready_r;
    assign bus.o_busy      = busy_r;
    assign bus.o_done      = done_r;
    assign bus.o_error     = error_r;
    assign bus.o_mem_we    = ~fifo_empty_s;
    assign bus.o_mem_addr  = addr_r;
    assign bus.o_mem_wdata = fifo_dout_s;

endmodule
